// File: rtl/rx_det_seq_if.sv
// rx_det_seq_if: per-lane receiver-detect handshake between the sequencer and the PHY.
//   rx_det_seq_req  sequencer -> PHY  one-hot-or-zero detect request
//   rx_det_seq_ack  PHY -> sequencer  per-lane detect-complete ack
//   rx_det          PHY -> sequencer  per-lane detect level, valid in the ack cycle
interface rx_det_seq_if #(
    parameter int NUM_LANES = 4
);
    logic [NUM_LANES-1:0] rx_det_seq_req;
    logic [NUM_LANES-1:0] rx_det_seq_ack;
    logic [NUM_LANES-1:0] rx_det;
    modport master (output rx_det_seq_req, input rx_det_seq_ack, input rx_det);
    modport slave  (input rx_det_seq_req, output rx_det_seq_ack, output rx_det);
endinterface

// File: rtl/rx_det_seq.sv
// rx_det_seq: runs receiver detection lane by lane through one shared detect circuit.
//   clk, rst     clock, synchronous active-high reset
//   start        single-cycle pass request, accepted only in IDLE
//   lane_mask    lanes to detect, captured when start is accepted
//   busy, done   pass in progress / one-cycle end-of-pass pulse
//   det_result   lane acked with rx_det high
//   timeout_err  lane timed out waiting for ack
//   phy          req/ack/rx_det handshake to the PHY (master side)
module rx_det_seq #(
    parameter int NUM_LANES   = 4,
    parameter int ACK_TIMEOUT = 64,
    parameter int GAP_CYC     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_LANES-1:0] lane_mask,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_LANES-1:0] det_result,
    output logic [NUM_LANES-1:0] timeout_err,
    rx_det_seq_if.master         phy
);
    localparam int CW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int GW = GAP_CYC > 1 ? $clog2(GAP_CYC + 1) : 1;

    typedef enum logic [2:0] {IDLE, SCAN, REQ, GAP, DONE} state_t;

    state_t               state, state_nxt;
    logic [NUM_LANES-1:0] pend;
    logic [CW-1:0]        cur, low;
    logic [TW-1:0]        timer;
    logic [GW-1:0]        gap_cnt;
    logic                 ack_cur, tmo;

    // Only the lane currently being requested may complete the handshake.
    assign ack_cur = phy.rx_det_seq_ack[cur];
    assign tmo     = timer == TW'(ACK_TIMEOUT);

    // Lowest pending lane wins, so lanes are served in ascending order.
    always_comb begin
        low = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--)
            if (pend[i]) low = CW'(i);
    end

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? SCAN : IDLE;
            SCAN:    state_nxt = pend == '0 ? DONE : REQ;
            REQ:     state_nxt = (ack_cur || tmo) ? GAP : REQ;
            GAP:     state_nxt = gap_cnt >= GW'(GAP_CYC) ? SCAN : GAP;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy               = state != IDLE;
        done               = state == DONE;
        phy.rx_det_seq_req = state == REQ ? NUM_LANES'(1) << cur : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend        <= '0;
            cur         <= '0;
            timer       <= '0;
            gap_cnt     <= '0;
            det_result  <= '0;
            timeout_err <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    pend        <= lane_mask;
                    det_result  <= '0;
                    timeout_err <= '0;
                end
                SCAN: begin
                    cur   <= low;
                    timer <= TW'(1);
                end
                REQ: begin
                    // Ack takes priority over a simultaneous timeout.
                    if (ack_cur) det_result[cur] <= phy.rx_det[cur];
                    else if (tmo) timeout_err[cur] <= 1'b1;
                    else timer <= timer + 1'b1;
                    if (ack_cur || tmo) begin
                        pend[cur] <= 1'b0;
                        gap_cnt   <= GW'(1);
                    end
                end
                GAP: if (gap_cnt < GW'(GAP_CYC)) gap_cnt <= gap_cnt + 1'b1;
                default: ;
            endcase
        end
    end
endmodule
